jp_dev: RTL
===========

# jp_dev

Controller-side model of the NES serial joypad protocol: a 4021-style parallel-in/serial-out shift register driven by the console's `jp_latch`/`jp_clk` and answering on an active-low `jp_data` line. It sits between a local button source (USB/keyboard bridge, debug registers, test bench) and a real or emulated NES host port. It lets the FPGA stand in as controller 1 or 2. Optional turbo auto-fire on A/B is compile-time selectable.

## Interface
- `SYNC_STAGES`, 2: flops in each input synchronizer, minimum 2.
- `TURBO_FRAMES`, 2: polls per turbo phase toggle, range 1..255. Used only with `JP_DEV_TURBO_EN`.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `buttons` in 8: active-high pressed state, {right, left, down, up, start, select, B, A}. Bit 0 = A.
- `turbo_a` in 1: enables auto-fire on A. Ignored when the macro is off.
- `turbo_b` in 1: enables auto-fire on B. Ignored when the macro is off.
- `jp_latch` in 1: host latch pin, asynchronous to `clk`.
- `jp_clk` in 1: host shift clock pin, asynchronous to `clk`.
- `jp_data` out 1: serial button data, active-low (0 = pressed).
- `poll` out 1: one-cycle pulse on each detected latch falling edge.
- `poll_done` out 1: one-cycle pulse on the 8th shift after a latch.

## Operation
- Synchronize `jp_latch` and `jp_clk` through `SYNC_STAGES` flops each. Add one history flop per signal for edge detection.
  - `lat_s`: synchronized latch level.
  - `lat_fall`: latch falling edge.
  - `clk_rise`: clock rising edge.
- Hold an 8-bit shift register `sr` (active-high) and a 4-bit counter `cnt` that saturates at 8.
- `jp_data = ~sr[0]`.
- Priority, evaluated each cycle:
  1. **`lat_s` = 1:** load `sr` from `eff_buttons` every cycle and set `cnt` = 0. Any `clk_rise` is ignored.
  2. **`lat_fall`:** load `sr` one final time. Pulse `poll`. Ignore a coincident `clk_rise`.
  3. **`clk_rise` with `lat_s` = 0:** `sr <= {1'b1, sr[7:1]}`. If `cnt` < 8, increment `cnt`. Pulse `poll_done` when `cnt` goes 7→8.
- Bits appear on `jp_data` in this order: A, B, select, start, up, down, left, right. After 8 shifts `jp_data` stays 0, so the host reads 1s, matching a stock pad whose serial input is grounded.
- Shifts past 8 are accepted and keep shifting in 1s. `cnt` stays at 8 and there are no further `poll_done` pulses.
- Without the macro, `eff_buttons = buttons`.

## Timing
- Reset values:
  - `sr` = 0, so `jp_data` = 1 (released).
  - `cnt` = 0.
  - `poll` = 0, `poll_done` = 0.
  - All synchronizer and history flops = 0.
  - Turbo counter = 0, turbo phase = 0.
- Pin-to-`jp_data` latency is at most `SYNC_STAGES`+1 `clk` edges after the pin edge (3 at default).
- Host pulse high/low widths must each be at least `SYNC_STAGES`+1 cycles. Shorter pulses may be lost; this is not an error condition.
- The latched snapshot is `eff_buttons` as sampled on the cycle `lat_fall` is asserted. `buttons` changes after that cycle do not affect the current read.
- `poll` and `poll_done` are registered and last exactly one cycle.
- **Latch mid-read:** a latch rising edge during a partial read reloads `sr` and clears `cnt`. No `poll_done` is issued for the aborted read.
- **Reset mid-read:** asynchronous return to the reset values above. The next read begins only after a fresh latch.

## Configuration
- Macro: `JP_DEV_TURBO_EN`.
- **Defined:**
  - An 8-bit poll counter increments on each `poll`.
  - When it reaches `TURBO_FRAMES`-1, it wraps to 0 and toggles `phase`.
  - `eff_buttons[0] = buttons[0] | (turbo_a & phase)`.
  - `eff_buttons[1] = buttons[1] | (turbo_b & phase)`.
  - All other bits pass through unchanged.
- **Undefined:**
  - No counter and no phase flop are built.
  - `turbo_a` and `turbo_b` are left unconnected logically.
  - `eff_buttons = buttons`.

## Test plan
- **Basic read:** `buttons`=8'h81, latch high 32 cycles, low, then 8 clk pulses of 32 cycles each → `jp_data` before each pulse reads 0,1,1,1,1,1,1,0; one `poll`; one `poll_done` after the 8th shift.
- **Over-read and hold:** 12 clk pulses after a latch → pulses 9–12 all give `jp_data`=0. Changing `buttons` to 8'hFF after `lat_fall` leaves read bits 2–8 unchanged.
- **Reload mid-read:** latch again after 3 shifts with `buttons`=8'h02 → first bit `jp_data`=1, second 0; no `poll_done` for the aborted read.
- **Edge collision:** `jp_latch` falls and `jp_clk` rises on the same `clk` cycle, `buttons`=8'h01 → `jp_data`=0 (A) and no shift occurs.
- **Reset:** `rst_n` low at an arbitrary point during shift 5 → `jp_data`=1 immediately, `cnt`=0. The next full read returns the current `buttons`.
- **Turbo (macro on, `TURBO_FRAMES`=2):** `turbo_a`=1, `buttons`=0, 8 polls → A bit reads 0,0,1,1,0,0,1,1. With the macro off, A reads 0 on every poll.

Source files
------------

// File: rtl/jp_dev_if.sv
// Host-side NES joypad port.
//   jp_latch : host latch pin (host -> pad)
//   jp_clk   : host shift clock pin (host -> pad)
//   jp_data  : serial button data, active-low (pad -> host)
// master = console/host side, slave = controller (jp_dev) side.
interface jp_dev_if;
  logic jp_latch;
  logic jp_clk;
  logic jp_data;

  modport master (output jp_latch, output jp_clk, input jp_data);
  modport slave  (input jp_latch, input jp_clk, output jp_data);
endinterface

// File: rtl/jp_dev.sv
// jp_dev: controller-side model of the NES serial joypad (4021-style PISO).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   buttons    pressed state {right,left,down,up,start,select,B,A}, bit 0 = A
//   turbo_a/b  auto-fire enables for A/B (only used with JP_DEV_TURBO_EN)
//   jp         host port (jp_latch, jp_clk in; jp_data out, active-low)
//   poll       one-cycle pulse per detected latch falling edge
//   poll_done  one-cycle pulse on the 8th shift after a latch
//
// Optional feature macro: JP_DEV_TURBO_EN (turbo auto-fire on A/B).
//
// The host pins are asynchronous to clk; each passes through SYNC_STAGES
// flops plus one history flop used for edge detection. While the latch is
// high the shift register tracks the buttons continuously; the falling edge
// takes the final snapshot. Each host clock rise shifts toward bit 0 and
// fills with 1 (pressed), so the host reads 1s after the 8th bit, like a
// stock pad with its serial input grounded.
module jp_dev #(
  parameter int SYNC_STAGES  = 2,
  parameter int TURBO_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] buttons,
  input  logic       turbo_a,
  input  logic       turbo_b,
  jp_dev_if.slave    jp,
  output logic       poll,
  output logic       poll_done
);

  logic [SYNC_STAGES-1:0] lat_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   lat_hist;
  logic                   clk_hist;
  logic                   lat_s;
  logic                   clk_s;
  logic                   lat_fall;
  logic                   clk_rise;
  logic [7:0]             eff_buttons;
  logic [7:0]             sr;
  logic [3:0]             cnt;

  // Input synchronizers and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_sync <= '0;
      clk_sync <= '0;
      lat_hist <= 1'b0;
      clk_hist <= 1'b0;
    end else begin
      lat_sync <= {lat_sync[SYNC_STAGES-2:0], jp.jp_latch};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], jp.jp_clk};
      lat_hist <= lat_sync[SYNC_STAGES-1];
      clk_hist <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign lat_s    = lat_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign lat_fall = lat_hist & ~lat_s;
  assign clk_rise = clk_s & ~clk_hist;

`ifdef JP_DEV_TURBO_EN
  localparam logic [7:0] TURBO_LAST = 8'(TURBO_FRAMES - 1);

  logic [7:0] turbo_cnt;
  logic       phase;

  // Phase flips every TURBO_FRAMES polls. It advances on the registered
  // poll pulse, i.e. after the snapshot of the current poll was taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turbo_cnt <= 8'd0;
      phase     <= 1'b0;
    end else if (poll) begin
      if (turbo_cnt == TURBO_LAST) begin
        turbo_cnt <= 8'd0;
        phase     <= ~phase;
      end else begin
        turbo_cnt <= turbo_cnt + 8'd1;
      end
    end
  end

  assign eff_buttons = {buttons[7:2],
                        buttons[1] | (turbo_b & phase),
                        buttons[0] | (turbo_a & phase)};
`else
  logic unused_turbo;
  assign unused_turbo = turbo_a | turbo_b;
  assign eff_buttons  = buttons;
`endif

  // Shift register and saturating bit counter.
  // Priority: latch level > latch falling edge > clock rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= 8'd0;
      cnt       <= 4'd0;
      poll      <= 1'b0;
      poll_done <= 1'b0;
    end else begin
      poll      <= 1'b0;
      poll_done <= 1'b0;
      if (lat_s) begin
        sr  <= eff_buttons;
        cnt <= 4'd0;
      end else if (lat_fall) begin
        sr   <= eff_buttons;
        poll <= 1'b1;
      end else if (clk_rise) begin
        sr <= {1'b1, sr[7:1]};
        if (cnt != 4'd8) begin
          cnt <= cnt + 4'd1;
        end
        poll_done <= (cnt == 4'd7);
      end
    end
  end

  assign jp.jp_data = ~sr[0];

endmodule
